// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - PC / IR / data-address sequencer arbitrating fetch, data and branch onto one memory port
module mem_access_unit #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int OFFW     = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            data_req,
    input  logic            data_we,
    input  logic [AW-1:0]   data_addr_in,
    input  logic [DW-1:0]   wdata_in,
    input  logic            branch_en,
    input  logic [1:0]      branch_mode,
    input  logic [OFFW-1:0] branch_off,
    input  logic [AW-1:0]   branch_target,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [1:0]      mem_cmd,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW-1:0]   ir_out,
    output logic [DW-1:0]   rdata_out,
    output logic [AW-1:0]   pc_out,
    output logic [AW-1:0]   link_out,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam int         WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_DATA  = 2'b10
    } state_t;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_pc, w_pc_next;
    logic [DW-1:0] r_ir, w_ir_next;
    logic [DW-1:0] r_rdata, w_rdata_next;
    logic [AW-1:0] r_link, w_link_next;
    logic [AW-1:0] r_daddr, w_daddr_next;
    logic [DW-1:0] r_wdata, w_wdata_next;
    logic          r_we, w_we_next;
    logic [WDW-1:0] r_wd, w_wd_next;
    logic          w_done_next;
    logic          r_done;
    logic          r_err, w_err_next;
    logic [1:0]    r_cmd, w_cmd_next;
    logic [AW-1:0] r_addr, w_addr_next;
    logic [AW-1:0] w_off_sext;

    assign w_off_sext = AW'($signed(branch_off));

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_rdata_next = r_rdata;
        w_link_next  = r_link;
        w_daddr_next = r_daddr;
        w_wdata_next = r_wdata;
        w_we_next    = r_we;
        w_wd_next    = r_wd;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        w_cmd_next   = CMD_NONE;
        w_addr_next  = r_pc;

        case (r_state)
            S_IDLE: begin
                if (branch_en) begin
                    if (branch_mode[1]) begin
                        w_link_next = r_pc;
                    end
                    w_pc_next = branch_mode[0] ? branch_target : r_pc + w_off_sext;
                end else if (fetch_req) begin
                    w_state_next = S_FETCH;
                    w_wd_next    = '0;
                end else if (data_req) begin
                    w_state_next = S_DATA;
                    w_daddr_next = data_addr_in;
                    w_wdata_next = wdata_in;
                    w_we_next    = data_we;
                    w_wd_next    = '0;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_ir_next    = mem_rdata;
                    w_pc_next    = r_pc + 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wd == WD_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            S_DATA: begin
                if (mem_ready) begin
                    if (!r_we) begin
                        w_rdata_next = mem_rdata;
                    end
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wd == WD_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Memory-side outputs are registered, so derive them from the state being entered.
        case (w_state_next)
            S_FETCH: begin
                w_cmd_next  = CMD_READ;
                w_addr_next = w_pc_next;
            end
            S_DATA: begin
                w_cmd_next  = w_we_next ? CMD_WRITE : CMD_READ;
                w_addr_next = w_daddr_next;
            end
            default: begin
                w_cmd_next  = CMD_NONE;
                w_addr_next = w_pc_next;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= AW'(RESET_PC);
            r_ir    <= '0;
            r_rdata <= '0;
            r_link  <= '0;
            r_daddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_wd    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cmd   <= CMD_NONE;
            r_addr  <= AW'(RESET_PC);
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_rdata <= w_rdata_next;
            r_link  <= w_link_next;
            r_daddr <= w_daddr_next;
            r_wdata <= w_wdata_next;
            r_we    <= w_we_next;
            r_wd    <= w_wd_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_cmd   <= w_cmd_next;
            r_addr  <= w_addr_next;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_addr  = r_addr;
    assign mem_cmd   = r_cmd;
    assign mem_wdata = r_wdata;
    assign ir_out    = r_ir;
    assign rdata_out = r_rdata;
    assign pc_out    = r_pc;
    assign link_out  = r_link;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic        data_req;
    logic        data_we;
    logic [8:0]  data_addr_in;
    logic [15:0] wdata_in;
    logic        branch_en;
    logic [1:0]  branch_mode;
    logic [7:0]  branch_off;
    logic [8:0]  branch_target;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] mem_wdata;
    logic [15:0] ir_out;
    logic [15:0] rdata_out;
    logic [8:0]  pc_out;
    logic [8:0]  link_out;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_addr_in  (data_addr_in),
        .wdata_in      (wdata_in),
        .branch_en     (branch_en),
        .branch_mode   (branch_mode),
        .branch_off    (branch_off),
        .branch_target (branch_target),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .mem_cmd       (mem_cmd),
        .mem_wdata     (mem_wdata),
        .ir_out        (ir_out),
        .rdata_out     (rdata_out),
        .pc_out        (pc_out),
        .link_out      (link_out),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (pc_out !== 9'h000 || ir_out !== 16'h0 || rdata_out !== 16'h0 || link_out !== 9'h0) begin
            n_errors++;
            $display("FAIL reset_regs pc=%h ir=%h rdata=%h link=%h expected all 0", pc_out, ir_out, rdata_out, link_out);
        end
        n_checks++;
        if (mem_cmd !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_addr !== 9'h000) begin
            n_errors++;
            $display("FAIL reset_ctl cmd=%b busy=%b done=%b err=%b addr=%h expected 00 0 0 0 000", mem_cmd, busy, done, err, mem_addr);
        end
    endtask

    task automatic test_fetch();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_checks++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'h000 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL fetch_issue cmd=%b addr=%h busy=%b expected 01 000 1", mem_cmd, mem_addr, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || mem_cmd !== 2'b01) begin
            n_errors++;
            $display("FAIL fetch_wait done=%b cmd=%b expected 0 01", done, mem_cmd);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hA55A;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (ir_out !== 16'hA55A || pc_out !== 9'h001 || done !== 1'b1 || busy !== 1'b0 || mem_cmd !== 2'b00) begin
            n_errors++;
            $display("FAIL fetch_done ir=%h pc=%h done=%b busy=%b cmd=%b expected a55a 001 1 0 00", ir_out, pc_out, done, busy, mem_cmd);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_done_pulse done=%b expected 0", done);
        end
    endtask

    task automatic test_branch();
        branch_en     = 1'b1;
        branch_mode   = 2'b01;
        branch_target = 9'h005;
        step();
        n_checks++;
        if (pc_out !== 9'h005 || link_out !== 9'h000) begin
            n_errors++;
            $display("FAIL branch_abs pc=%h link=%h expected 005 000", pc_out, link_out);
        end
        branch_mode = 2'b10;
        branch_off  = 8'hFD;
        step();
        n_checks++;
        if (pc_out !== 9'h002 || link_out !== 9'h005 || mem_cmd !== 2'b00 || busy !== 1'b0 || mem_addr !== 9'h002) begin
            n_errors++;
            $display("FAIL branch_rel_link pc=%h link=%h cmd=%b busy=%b addr=%h expected 002 005 00 0 002", pc_out, link_out, mem_cmd, busy, mem_addr);
        end
        branch_mode   = 2'b01;
        branch_target = 9'h1FF;
        step();
        branch_en = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_checks++;
        if (mem_addr !== 9'h1FF || mem_cmd !== 2'b01) begin
            n_errors++;
            $display("FAIL branch_fetch_issue addr=%h cmd=%b expected 1ff 01", mem_addr, mem_cmd);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h0F0F;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (pc_out !== 9'h000 || ir_out !== 16'h0F0F || done !== 1'b1 || link_out !== 9'h005) begin
            n_errors++;
            $display("FAIL pc_wrap pc=%h ir=%h done=%b link=%h expected 000 0f0f 1 005", pc_out, ir_out, done, link_out);
        end
    endtask

    task automatic test_store_load();
        data_req     = 1'b1;
        data_we      = 1'b1;
        data_addr_in = 9'h040;
        wdata_in     = 16'h1234;
        step();
        data_req     = 1'b0;
        wdata_in     = 16'hFFFF;
        data_addr_in = 9'h1AA;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem_cmd !== 2'b10 || mem_wdata !== 16'h1234 || mem_addr !== 9'h040 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL store_wait%0d cmd=%b wdata=%h addr=%h done=%b expected 10 1234 040 0", i, mem_cmd, mem_wdata, mem_addr, done);
            end
            step();
        end
        n_checks++;
        if (mem_cmd !== 2'b10 || mem_wdata !== 16'h1234) begin
            n_errors++;
            $display("FAIL store_last cmd=%b wdata=%h expected 10 1234", mem_cmd, mem_wdata);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || mem_cmd !== 2'b00 || rdata_out !== 16'h0000) begin
            n_errors++;
            $display("FAIL store_done done=%b cmd=%b rdata=%h expected 1 00 0000", done, mem_cmd, rdata_out);
        end
        data_req     = 1'b1;
        data_we      = 1'b0;
        data_addr_in = 9'h040;
        step();
        data_req = 1'b0;
        n_checks++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'h040) begin
            n_errors++;
            $display("FAIL load_issue cmd=%b addr=%h expected 01 040", mem_cmd, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (rdata_out !== 16'h1234 || done !== 1'b1 || pc_out !== 9'h000) begin
            n_errors++;
            $display("FAIL load_done rdata=%h done=%b pc=%h expected 1234 1 000", rdata_out, done, pc_out);
        end
    endtask

    task automatic test_priority();
        branch_en    = 1'b1;
        branch_mode  = 2'b00;
        branch_off   = 8'h03;
        fetch_req    = 1'b1;
        data_req     = 1'b1;
        data_we      = 1'b0;
        data_addr_in = 9'h077;
        step();
        branch_en = 1'b0;
        n_checks++;
        if (pc_out !== 9'h003 || busy !== 1'b0 || mem_cmd !== 2'b00) begin
            n_errors++;
            $display("FAIL prio_branch pc=%h busy=%b cmd=%b expected 003 0 00", pc_out, busy, mem_cmd);
        end
        step();
        n_checks++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'h003) begin
            n_errors++;
            $display("FAIL prio_fetch cmd=%b addr=%h expected 01 003", mem_cmd, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        fetch_req = 1'b0;
        mem_ready = 1'b0;
        n_checks++;
        if (ir_out !== 16'hBEEF || pc_out !== 9'h004 || done !== 1'b1 || mem_cmd !== 2'b00) begin
            n_errors++;
            $display("FAIL prio_fetch_done ir=%h pc=%h done=%b cmd=%b expected beef 004 1 00", ir_out, pc_out, done, mem_cmd);
        end
        step();
        data_req = 1'b0;
        n_checks++;
        if (mem_cmd !== 2'b01 || mem_addr !== 9'h077 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_data cmd=%b addr=%h busy=%b expected 01 077 1", mem_cmd, mem_addr, busy);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h5555;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (rdata_out !== 16'h5555 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_data_done rdata=%h done=%b expected 5555 1", rdata_out, done);
        end
    endtask

    task automatic test_timeout();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout_wait%0d busy=%b done=%b err=%b expected 1 0 0", i, busy, done, err);
            end
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0 || pc_out !== 9'h004 || ir_out !== 16'hBEEF || mem_cmd !== 2'b00) begin
            n_errors++;
            $display("FAIL timeout_abort busy=%b err=%b done=%b pc=%h ir=%h cmd=%b expected 0 1 0 004 beef 00", busy, err, done, pc_out, ir_out, mem_cmd);
        end
        step();
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_sticky err=%b done=%b expected 1 0", err, done);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (err !== 1'b0 || pc_out !== 9'h000) begin
            n_errors++;
            $display("FAIL timeout_clear err=%b pc=%h expected 0 000", err, pc_out);
        end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 14; i++) step();
        mem_ready = 1'b1;
        mem_rdata = 16'h1111;
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || ir_out !== 16'h1111 || pc_out !== 9'h001) begin
            n_errors++;
            $display("FAIL timeout_edge_ok done=%b err=%b ir=%h pc=%h expected 1 0 1111 001", done, err, ir_out, pc_out);
        end
    endtask

    task automatic test_reset_mid_access();
        data_req     = 1'b1;
        data_we      = 1'b0;
        data_addr_in = 9'h010;
        step();
        data_req = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b1 || mem_cmd !== 2'b01) begin
            n_errors++;
            $display("FAIL midreset_pre busy=%b cmd=%b expected 1 01", busy, mem_cmd);
        end
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'h7777;
        step();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mem_cmd !== 2'b00 || pc_out !== 9'h000 || err !== 1'b0 || done !== 1'b0 || rdata_out !== 16'h0 || ir_out !== 16'h0) begin
            n_errors++;
            $display("FAIL midreset busy=%b cmd=%b pc=%h err=%b done=%b rdata=%h ir=%h expected 0 00 000 0 0 0000 0000", busy, mem_cmd, pc_out, err, done, rdata_out, ir_out);
        end
        step();
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rdata_out !== 16'h0) begin
            n_errors++;
            $display("FAIL idle_ready_ignored done=%b busy=%b rdata=%h expected 0 0 0000", done, busy, rdata_out);
        end
    endtask

    initial begin
        reset         = 1'b1;
        fetch_req     = 1'b0;
        data_req      = 1'b0;
        data_we       = 1'b0;
        data_addr_in  = '0;
        wdata_in      = '0;
        branch_en     = 1'b0;
        branch_mode   = 2'b00;
        branch_off    = '0;
        branch_target = '0;
        mem_ready     = 1'b0;
        mem_rdata     = '0;

        test_reset();
        test_fetch();
        test_branch();
        test_store_load();
        test_priority();
        test_timeout();
        test_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
